// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word accesses into aligned word bus
// transactions with lane steering, load extension and a bus-timeout error.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic [2:0]  load_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int unsigned   CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          we_q, we_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          req_illegal;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic          timeout;

  // Decode of the incoming request: legality, byte lanes and replicated store data.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    req_illegal = 1'b0;
    req_be      = 4'b0000;
    req_wdata   = wdata;
    case (load_store)
      3'b000: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      3'b100: begin
        req_illegal = mem_write;
        req_be      = 4'b0001 << addr[1:0];
        req_wdata   = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_illegal = addr[0] | (mem_write & load_store[2]);
        req_be      = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata   = {2{wdata[15:0]}};
      end
      3'b010: begin
        req_illegal = |addr[1:0];
        req_be      = 4'b1111;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (code_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'b0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'b0, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == WAIT_LIMIT);

  // A grant or read-data beat is tested before the timeout, so it wins a tie.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    code_d      = code_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = mem_write;
          code_d      = load_store;
          off_d       = addr[1:0];
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = req_be;
          mem_wdata_d = req_wdata;
          cnt_d       = '0;
          if (req_illegal) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d = '0;
          if (we_q) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end else if (timeout) begin
          state_d     = S_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d   = S_IDLE;
        rsp_err_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // NOTE: datapath registers are reset too, so bus and response outputs are defined from time zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      code_q      <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      code_q      <= code_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model,
// per-cycle comparison, directed corner cases and randomized traffic.
module tb_load_store_unit;

  localparam int MW = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  load_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .load_store(load_store), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g: REQ cycles before the grant; r: WAIT cycles before read data (>= MW means never).
  typedef struct {
    bit        we;
    bit [2:0]  code;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        g;
    int        r;
  } txn_t;

  typedef struct {
    bit        illegal;
    bit [3:0]  be;
    bit [31:0] word_addr;
    bit [31:0] wrep;
    bit [31:0] rdata;
    bit        err;
    int        req_cycles;
    int        lat;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  txn_t        cur_t;
  exp_t        cur_e;
  bit          exp_ready, exp_req, exp_rsp;
  bit [31:0]   exp_rdata;
  int          k;
  int          obs_req_n, obs_rsp_k;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_err;

  function automatic exp_t model(txn_t t);
    exp_t      e;
    int        off;
    bit [31:0] b, h, val;
    e   = '{default: '0};
    off = int'(t.addr % 32'd4);
    e.word_addr = t.addr - 32'(off);
    e.illegal = (t.code inside {3'd3, 3'd6, 3'd7}) ||
                (t.we && (t.code inside {3'd4, 3'd5})) ||
                ((t.code inside {3'd1, 3'd5}) && (off % 2 == 1)) ||
                (t.code == 3'd2 && off != 0);
    b = (t.rdata >> (8 * off)) & 32'hFF;
    h = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (t.code)
      3'd0, 3'd4: begin
        e.be   = 4'(1 << off);
        e.wrep = (t.wdata & 32'hFF) * 32'h0101_0101;
        val    = (t.code == 3'd0 && b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      end
      3'd1, 3'd5: begin
        e.be   = 4'(3 << (2 * (off / 2)));
        e.wrep = (t.wdata & 32'hFFFF) * 32'h0001_0001;
        val    = (t.code == 3'd1 && h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      end
      default: begin
        e.be   = 4'hF;
        e.wrep = t.wdata;
        val    = t.rdata;
      end
    endcase
    if (e.illegal) begin
      e.err = 1'b1; e.req_cycles = 0; e.lat = 1; e.rdata = 32'h0;
    end else if (t.g >= MW) begin
      e.err = 1'b1; e.req_cycles = MW; e.lat = MW + 1; e.rdata = 32'h0;
    end else if (t.we) begin
      e.err = 1'b0; e.req_cycles = t.g + 1; e.lat = t.g + 2; e.rdata = 32'h0;
    end else if (t.r >= MW) begin
      e.err = 1'b1; e.req_cycles = t.g + 1; e.lat = t.g + 2 + MW; e.rdata = 32'h0;
    end else begin
      e.err = 1'b0; e.req_cycles = t.g + 1; e.lat = t.g + t.r + 3; e.rdata = val;
    end
    return e;
  endfunction

  function automatic int pick_delay();
    int s;
    s = int'($urandom_range(0, 9));
    if (s < 7)  return int'($urandom_range(0, 3));
    if (s == 7) return MW - 1;
    if (s == 8) return MW;
    return MW + 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (k=%0d t=%0t): got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model's expectation.
  task automatic compare();
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    if (mem_req === 1'b1) begin
      obs_req_n++;
      obs_addr  = mem_addr;
      obs_be    = mem_be;
      obs_wdata = mem_wdata;
    end
    if (exp_req && mem_req === 1'b1) begin
      check("mem_addr", mem_addr, cur_e.word_addr);
      check("mem_be", 32'(mem_be), 32'(cur_e.be));
      check("mem_we", 32'(mem_we), 32'(cur_t.we));
      if (cur_t.we) check("mem_wdata", mem_wdata, cur_e.wrep);
    end
    if (rsp_valid === 1'b1) begin
      obs_rsp_k = k;
      obs_rdata = rsp_rdata;
      obs_err   = rsp_err;
    end
    if (exp_rsp && rsp_valid === 1'b1) check("rsp_err", 32'(rsp_err), 32'(cur_e.err));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    mem_gnt    = 1'($urandom_range(0, 1));
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
  endtask

  task automatic scramble_req();
    req_valid  = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    load_store = 3'($urandom_range(0, 7));
    addr       = $urandom;
    wdata      = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      k = 0;
      req_valid = 1'b0;
      noise();
      exp_ready = 1'b1; exp_req = 1'b0; exp_rsp = 1'b0;
      next_cycle();
    end
  endtask

  task automatic run_txn(input txn_t t);
    bit in_wait;
    cur_t = t;
    cur_e = model(t);
    k = 0; obs_req_n = 0; obs_rsp_k = -1;
    noise();
    req_valid = 1'b1; mem_write = t.we; load_store = t.code; addr = t.addr; wdata = t.wdata;
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp = 1'b0;
    next_cycle();
    for (int kk = 1; kk <= cur_e.lat; kk++) begin
      k = kk;
      scramble_req();
      noise();
      exp_ready = 1'b0;
      exp_req   = (kk <= cur_e.req_cycles);
      exp_rsp   = (kk == cur_e.lat);
      in_wait   = !t.we && !cur_e.illegal && t.g < MW && kk > cur_e.req_cycles && kk < cur_e.lat;
      if (exp_req) mem_gnt = (kk == t.g + 1);
      if (in_wait) begin
        mem_rvalid = (kk == t.g + 2 + t.r);
        if (mem_rvalid) mem_rdata = t.rdata;
      end
      if (exp_rsp) exp_rdata = cur_e.rdata;
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    txn_t t;
    rst_n = 1'b0; req_valid = 1'b0; mem_write = 1'b0; load_store = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp = 1'b0; exp_rdata = 32'h0;
    k = 0; obs_req_n = 0; obs_rsp_k = -1;
    cur_t = '{default: '0}; cur_e = '{default: '0};
    @(posedge clk); #1;
    next_cycle(); next_cycle();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // SB to the top byte lane, immediate grant.
    t = '{we: 1'b1, code: 3'd0, addr: 32'h1003, wdata: 32'h0000_00A5, rdata: 32'h0, g: 0, r: 0};
    run_txn(t);
    check("sb_be", 32'(obs_be), 32'h8);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    check("sb_addr", obs_addr, 32'h1000);
    check("sb_latency", 32'(obs_rsp_k), 32'd2);
    check("sb_err", 32'(obs_err), 32'h0);
    idle(1);

    // LB / LBU of lane 1, read data one cycle after the grant.
    t = '{we: 1'b0, code: 3'd0, addr: 32'h2001, wdata: 32'h0, rdata: 32'h0000_F000, g: 0, r: 0};
    run_txn(t);
    check("lb_rdata", obs_rdata, 32'hFFFF_FFF0);
    check("lb_latency", 32'(obs_rsp_k), 32'd3);
    t.code = 3'd4;
    run_txn(t);
    check("lbu_rdata", obs_rdata, 32'h0000_00F0);

    // Misaligned accesses answer in one cycle with no bus request.
    t = '{we: 1'b0, code: 3'd1, addr: 32'h3001, wdata: 32'h0, rdata: 32'h0, g: 0, r: 0};
    run_txn(t);
    check("lh_mis_req", 32'(obs_req_n), 32'd0);
    check("lh_mis_latency", 32'(obs_rsp_k), 32'd1);
    check("lh_mis_err", 32'(obs_err), 32'h1);
    t = '{we: 1'b1, code: 3'd2, addr: 32'h3002, wdata: 32'h1234_5678, rdata: 32'h0, g: 0, r: 0};
    run_txn(t);
    check("sw_mis_req", 32'(obs_req_n), 32'd0);
    check("sw_mis_err", 32'(obs_err), 32'h1);

    // Grant never arrives: bus timeout.
    t = '{we: 1'b0, code: 3'd2, addr: 32'h5000, wdata: 32'h0, rdata: 32'h0, g: MW + 3, r: 0};
    run_txn(t);
    check("lw_to_req_cycles", 32'(obs_req_n), 32'(MW));
    check("lw_to_err", 32'(obs_err), 32'h1);
    check("lw_to_latency", 32'(obs_rsp_k), 32'(MW + 1));

    // Grant on the last allowed cycle beats the timeout.
    t = '{we: 1'b1, code: 3'd2, addr: 32'h6000, wdata: 32'hDEAD_BEEF, rdata: 32'h0, g: MW - 1, r: 0};
    run_txn(t);
    check("sw_tie_err", 32'(obs_err), 32'h0);
    check("sw_tie_latency", 32'(obs_rsp_k), 32'(MW + 1));

    // LHU of the upper half.
    t = '{we: 1'b0, code: 3'd5, addr: 32'h4002, wdata: 32'h0, rdata: 32'h8001_7FFF, g: 0, r: 0};
    run_txn(t);
    check("lhu_rdata", obs_rdata, 32'h0000_8001);
    idle(1);

    // Reset while waiting for read data; the late beat must be ignored.
    cur_t = t; cur_e = model(t); obs_rsp_k = -1; k = 0;
    req_valid = 1'b1; mem_write = 1'b0; load_store = 3'd5; addr = 32'h4002; wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_ready = 1'b1; exp_req = 1'b0; exp_rsp = 1'b0;
    next_cycle();
    k = 1; req_valid = 1'b0; mem_gnt = 1'b1; exp_ready = 1'b0; exp_req = 1'b1;
    next_cycle();
    k = 2; mem_gnt = 1'b0; exp_req = 1'b0;
    next_cycle();
    k = 3; rst_n = 1'b0; exp_ready = 1'b1; exp_rdata = 32'h0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle(); next_cycle();
    check("rst_no_rsp", 32'(obs_rsp_k), 32'hFFFF_FFFF);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.code  = 3'($urandom_range(0, 7));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.g     = pick_delay();
      t.r     = pick_delay();
      run_txn(t);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
